// File: rtl/serial_subtractor.sv
// serial_subtractor: LSB-first bit-serial unsigned subtractor with a valid/ready handshake.
// Define SERIAL_SUB_ABS_DIFF_EN to return |a - b| through an extra serial negate pass.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             done_valid,
    input  logic             done_ready
);
    localparam int CW = $clog2(WIDTH);

`ifdef SERIAL_SUB_ABS_DIFF_EN
    typedef enum logic [1:0] {IDLE, SHIFT, NEGATE, DONE} state_t;
    logic seen;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t state, state_n;
    logic [WIDTH-1:0] sa, sb, res;
    logic [CW-1:0] cnt;
    logic br, d, bn, last;

    always_comb begin
        d    = sa[0] ^ sb[0] ^ br;
        bn   = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
        last = cnt == CW'(WIDTH - 1);
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:   state_n = start_valid ? SHIFT : IDLE;
`ifdef SERIAL_SUB_ABS_DIFF_EN
            SHIFT:  state_n = last ? (bn ? NEGATE : DONE) : SHIFT;
            NEGATE: state_n = last ? DONE : NEGATE;
`else
            SHIFT:  state_n = last ? DONE : SHIFT;
`endif
            DONE:   state_n = done_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa  <= '0;
            sb  <= '0;
            res <= '0;
            br  <= 1'b0;
            cnt <= '0;
`ifdef SERIAL_SUB_ABS_DIFF_EN
            seen <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (start_valid) begin
                    sa  <= a;
                    sb  <= b;
                    br  <= 1'b0;
                    cnt <= '0;
                end
                SHIFT: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    res <= {d, res[WIDTH-1:1]};
                    br  <= bn;
                    cnt <= last ? '0 : cnt + 1'b1;
`ifdef SERIAL_SUB_ABS_DIFF_EN
                    seen <= 1'b0;
`endif
                end
`ifdef SERIAL_SUB_ABS_DIFF_EN
                // Two's complement: copy bits through the first 1, invert the rest.
                NEGATE: begin
                    res  <= {seen ? ~res[0] : res[0], res[WIDTH-1:1]};
                    seen <= seen | res[0];
                    cnt  <= last ? '0 : cnt + 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign start_ready = state == IDLE;
    assign done_valid  = state == DONE;
    assign diff        = res;
    assign borrow      = br;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: randomized and directed checks of serial_subtractor against an arithmetic model.
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk = 0, rst = 1, start_valid = 0, done_ready = 0;
    logic [W-1:0] a = 0, b = 0, diff;
    logic start_ready, borrow, done_valid;
    int total = 0, passed = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
        .a(a), .b(b), .diff(diff), .borrow(borrow),
        .done_valid(done_valid), .done_ready(done_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input int stall, input bit pulse);
        int lat, ex_lat;
        logic [W-1:0] ex_d;
        logic ex_b;
        ex_b = x < y;
        ex_d = W'(int'(x) - int'(y));
        ex_lat = W;
`ifdef SERIAL_SUB_ABS_DIFF_EN
        if (ex_b) begin
            ex_d = W'(int'(y) - int'(x));
            ex_lat = 2 * W;
        end
`endif
        check("start_ready", start_ready, 1);
        start_valid = 1; a = x; b = y;
        @(posedge clk); #1;
        start_valid = 0; a = $urandom; b = $urandom;
        lat = 0;
        while (!done_valid && lat < 100) begin
            done_ready = $urandom_range(0, 1);
            @(posedge clk); #1;
            lat++;
        end
        done_ready = 0;
        check("latency", lat, ex_lat);
        check("diff", diff, ex_d);
        check("borrow", borrow, ex_b);
        for (int i = 0; i < stall; i++) begin
            if (pulse) begin start_valid = 1; a = $urandom; b = $urandom; end
            @(posedge clk); #1;
            start_valid = 0;
            check("hold_valid", done_valid, 1);
            check("hold_diff", diff, ex_d);
            check("hold_borrow", borrow, ex_b);
            check("hold_sready", start_ready, 0);
        end
        done_ready = 1;
        @(posedge clk); #1;
        done_ready = 0;
        check("release_valid", done_valid, 0);
        check("release_diff", diff, ex_d);
        check("release_borrow", borrow, ex_b);
    endtask

    initial begin
        a = 8'h5A; b = 8'hA5;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check("rst_valid", done_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow, 0);
        check("rst_sready", start_ready, 1);
        run_op(8'h35, 8'h12, 0, 0);
        run_op(8'h12, 8'h35, 0, 0);
        run_op(8'hFF, 8'hFF, 0, 0);
        run_op(8'h00, 8'h01, 0, 0);
        run_op(8'h80, 8'h7F, 0, 0);
        run_op(8'h12, 8'h35, 5, 1);
        run_op(8'h35, 8'h12, 0, 0);
        // Reset landing on the third SHIFT edge
        start_valid = 1; a = 8'hC3; b = 8'h3C;
        @(posedge clk); #1;
        start_valid = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        rst = 0;
        check("midrst_valid", done_valid, 0);
        check("midrst_diff", diff, 0);
        check("midrst_borrow", borrow, 0);
        check("midrst_sready", start_ready, 1);
        run_op(8'h10, 8'h01, 0, 0);
        for (int i = 0; i < 1000; i++)
            run_op(W'($urandom), W'($urandom), $urandom_range(0, 3), $urandom_range(0, 1));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
